tpu_ctl: RTL and testbench
==========================

# tpu_ctl

Transmit packet unit controller. It is the sending-side counterpart of the NOU receive controller. It accepts a send request from the scheduler and emits a head flit. It waits for the remote head response, then streams `len` data flits out of the packet buffer and waits for the remote data response. Finally it reports completion or error to the scheduler. It sits between the scheduler/packet-buffer read port and the outbound flit encoder / inbound response decoder.

## Interface
Parameters:
- `LEN_W`, default 8: data-flit count width.
- `TICK_HOLD`, default 11000: stall-cycle limit before timeout.
- `TICK_W`, default 16: stall counter width. Must hold `TICK_HOLD`. An elaboration-time check fails if `TICK_HOLD >= 2**TICK_W`.

Widths `TYPE_W` = `` `NOU_TYPE_WIDTH `` and `ERR_W` = `` `NOU_ERR_CODE_WIDTH `` come from `nou_define.h`.

Reset: single clock `clk`; reset `rst` is synchronous, active-high.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `tx_req_vld` in 1: send request.
- `tx_req_len` in LEN_W: number of data flits.
- `tx_req_ready` out 1: request accepted when `vld&ready`.
- `ob_vld` out 1: flit to encoder valid.
- `ob_type` out TYPE_W: `HEAD_FLIT_TYPE` / `DATA_FLIT_TYPE`.
- `sel_head` out 1: encoder payload mux, 1 = head fields, 0 = buffer data.
- `ob_ready` in 1: encoder accepts flit.
- `start_rd` out 1: one-cycle pulse that starts the packet-buffer read address.
- `rd_vld` in 1: buffer read data available.
- `rd_en` out 1: pop buffer word.
- `ib_rsp_vld` in 1: remote response valid.
- `ib_rsp_type` in TYPE_W: response type.
- `ib_rsp_status` in 1: response status, `RSP_STATUS_OK` / `RSP_STATUS_ERR`.
- `ib_rsp_err` in ERR_W: remote error code.
- `ib_rsp_ready` out 1: response consumed.
- `done_vld` out 1: completion valid.
- `done_status` out 1: completion status.
- `done_err` out ERR_W: completion error code.
- `done_ready` in 1: scheduler accepts completion.
- `rel_buf` out 1: release the packet buffer.

## Operation
The FSM is 3-bit and has these states: IDLE, SEND_HEAD, WAIT_HEAD_RSP, SEND_DATA, WAIT_DATA_RSP, DONE, ERROR. All outputs are combinational from state and inputs, and default to 0.

IDLE:
- `tx_req_ready`=1.
- On `tx_req_vld`, latch `len`.
- If `len`==0, go to ERROR with err `BAD_TX_LEN`. Otherwise go to SEND_HEAD.

SEND_HEAD:
- `ob_vld`=1, `ob_type`=HEAD, `sel_head`=1.
- On `ob_ready`, go to WAIT_HEAD_RSP.

WAIT_HEAD_RSP:
- `ib_rsp_ready`=1.
- On `ib_rsp_vld`:
  - status ERR: go to ERROR with err = `ib_rsp_err`.
  - type≠HEAD: go to ERROR with err `BAD_RSP_TYPE`.
  - otherwise: go to SEND_DATA.

SEND_DATA:
- `ob_vld`=`rd_vld`, `ob_type`=DATA, `sel_head`=0, `rd_en`=`rd_vld&ob_ready`.
- The flit counter (LEN_W, cleared on SEND_DATA entry) increments on each transfer.
- A transfer with counter==`len`-1 goes to WAIT_DATA_RSP.

WAIT_DATA_RSP:
- Same rules as WAIT_HEAD_RSP, with expected type DATA.
- Success goes to DONE.

DONE:
- `done_vld`=1, `done_status`=OK, `done_err`=0.
- `rel_buf`=`done_ready`.
- On `done_ready`, go to IDLE.

ERROR:
- `done_vld`=1, `done_status`=ERR, `done_err`=latched code.
- `ib_rsp_ready`=1, so stray responses are dropped.
- On `done_ready`, go to IDLE.
- `rel_buf` is not asserted. The scheduler owns recovery.

Timeouts:
- Error codes: `TIME_OUT_OB_HEAD` (SEND_HEAD), `TIME_OUT_IB_HEAD_RSP`, `TIME_OUT_OB_DATA` (SEND_DATA), `TIME_OUT_IB_DATA_RSP`.
- `BAD_TX_LEN`, `BAD_RSP_TYPE` and the timeout codes are new macros added to `nou_define.h`.
- The error code register is written only on the transition into ERROR.

## Timing
- Reset: state IDLE, `len`/counter/tick/err cleared. Outputs after reset: `tx_req_ready`=1, all others 0.
- Reset mid-operation: abandons the packet. No `done_vld` and no `rel_buf` are issued.
- `start_rd` = (next==SEND_DATA)&&(state!=SEND_DATA). It pulses in the cycle the head response is accepted.
- Stall counter `tick`:
  - Cleared on every state change and on every flit/response transfer.
  - Otherwise increments by 1 per cycle in SEND_HEAD, WAIT_HEAD_RSP, SEND_DATA, WAIT_DATA_RSP.
  - In a cycle with `tick`==`TICK_HOLD` and no progress, next = ERROR. The timeout is therefore taken after `TICK_HOLD`+1 consecutive stalled cycles.
  - The counter never wraps.
- Simultaneous progress and timeout in the same cycle: progress wins.
- In SEND_DATA, a gap in `rd_vld` stalls without dropping flits. `ob_vld` may deassert only because `rd_vld` is low; the encoder tolerates this.
- Responses arriving outside WAIT_* and ERROR are back-pressured (`ib_rsp_ready`=0) and not dropped.
- Minimum latency for `len`=N with no stalls: 1 (IDLE) + 1 (head) + 1 (head rsp) + N (data) + 1 (data rsp) + 1 (done) = N+5 cycles from request to `done_vld&done_ready`.
- `len` is max 2^LEN_W−1. The counter compare is exact with no wrap.

## Test plan
- Nominal: `len`=4 with all ready/valid high. Required: 1 head flit, 4 data flits on consecutive cycles, `rd_en` 4 pulses, `start_rd` 1 pulse, `done_vld` with OK at cycle 9, `rel_buf` 1 pulse.
- Backpressure: `len`=3, `ob_ready` toggling 1/0, `rd_vld` gap of 5 cycles mid-stream. Required: exactly 3 data transfers in order, no extra `rd_en`, OK completion.
- Remote error: head response with status ERR, err=`NO_BUF_AVAILABLE`. Required: no data flits, `done_status`=ERR, `done_err`=`NO_BUF_AVAILABLE`, `rel_buf`=0.
- Timeout with `TICK_HOLD`=16: no data response. Required: ERROR entered after exactly 17 stalled cycles, `done_err`=`TIME_OUT_IB_DATA_RSP`. Repeat with the response arriving on stall cycle 17: required OK (progress wins).
- Bad inputs: `len`=0 gives `BAD_TX_LEN`. A DATA-type response in WAIT_HEAD_RSP gives `BAD_RSP_TYPE`. `done_ready` held low for 10 cycles keeps `done_vld` stable.
- `rst` asserted in SEND_DATA after 2 of 5 flits. Required: next cycle IDLE, `tx_req_ready`=1, other outputs 0. A new `len`=1 request then completes OK.

Source files
------------

// File: rtl/tpu_ctl.sv
// tpu_ctl: transmit packet unit controller.
// Accepts a send request, emits a head flit, waits for the remote head
// response, streams len data flits from the packet buffer, waits for the
// remote data response, then reports completion (or an error) to the scheduler.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tx_req_vld/len/ready        send request from scheduler
//   ob_vld/type/ready, sel_head flit to outbound encoder (sel_head=1: head fields)
//   start_rd, rd_vld, rd_en     packet-buffer read control
//   ib_rsp_vld/type/status/err  remote response, consumed with ib_rsp_ready
//   done_vld/status/err/ready   completion report to scheduler
//   rel_buf                     packet-buffer release (successful completion only)

`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 2
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef HEAD_FLIT_TYPE
`define HEAD_FLIT_TYPE 2'd1
`endif
`ifndef DATA_FLIT_TYPE
`define DATA_FLIT_TYPE 2'd2
`endif
`ifndef RSP_STATUS_OK
`define RSP_STATUS_OK 1'b0
`endif
`ifndef RSP_STATUS_ERR
`define RSP_STATUS_ERR 1'b1
`endif
`ifndef NO_BUF_AVAILABLE
`define NO_BUF_AVAILABLE 4'd1
`endif
`ifndef BAD_TX_LEN
`define BAD_TX_LEN 4'd8
`endif
`ifndef BAD_RSP_TYPE
`define BAD_RSP_TYPE 4'd9
`endif
`ifndef TIME_OUT_OB_HEAD
`define TIME_OUT_OB_HEAD 4'd10
`endif
`ifndef TIME_OUT_IB_HEAD_RSP
`define TIME_OUT_IB_HEAD_RSP 4'd11
`endif
`ifndef TIME_OUT_OB_DATA
`define TIME_OUT_OB_DATA 4'd12
`endif
`ifndef TIME_OUT_IB_DATA_RSP
`define TIME_OUT_IB_DATA_RSP 4'd13
`endif

module tpu_ctl #(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned TICK_HOLD = 11000,
  parameter int unsigned TICK_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tx_req_vld,
  input  logic [LEN_W-1:0]               tx_req_len,
  output logic                           tx_req_ready,
  output logic                           ob_vld,
  output logic [`NOU_TYPE_WIDTH-1:0]     ob_type,
  output logic                           sel_head,
  input  logic                           ob_ready,
  output logic                           start_rd,
  input  logic                           rd_vld,
  output logic                           rd_en,
  input  logic                           ib_rsp_vld,
  input  logic [`NOU_TYPE_WIDTH-1:0]     ib_rsp_type,
  input  logic                           ib_rsp_status,
  input  logic [`NOU_ERR_CODE_WIDTH-1:0] ib_rsp_err,
  output logic                           ib_rsp_ready,
  output logic                           done_vld,
  output logic                           done_status,
  output logic [`NOU_ERR_CODE_WIDTH-1:0] done_err,
  input  logic                           done_ready,
  output logic                           rel_buf
);

  localparam int unsigned TYPE_W = `NOU_TYPE_WIDTH;
  localparam int unsigned ERR_W  = `NOU_ERR_CODE_WIDTH;

  localparam logic [TYPE_W-1:0] HEAD_T   = `HEAD_FLIT_TYPE;
  localparam logic [TYPE_W-1:0] DATA_T   = `DATA_FLIT_TYPE;
  localparam logic              ST_OK    = `RSP_STATUS_OK;
  localparam logic              ST_ERR   = `RSP_STATUS_ERR;
  localparam logic [ERR_W-1:0]  E_LEN    = `BAD_TX_LEN;
  localparam logic [ERR_W-1:0]  E_TYPE   = `BAD_RSP_TYPE;
  localparam logic [ERR_W-1:0]  E_TO_OBH = `TIME_OUT_OB_HEAD;
  localparam logic [ERR_W-1:0]  E_TO_IBH = `TIME_OUT_IB_HEAD_RSP;
  localparam logic [ERR_W-1:0]  E_TO_OBD = `TIME_OUT_OB_DATA;
  localparam logic [ERR_W-1:0]  E_TO_IBD = `TIME_OUT_IB_DATA_RSP;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_HOLD);

  if (TICK_HOLD >= (64'd1 << TICK_W)) begin : g_tick_chk
    $error("tpu_ctl: TICK_HOLD does not fit in TICK_W bits");
  end

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    SEND_HEAD     = 3'd1,
    WAIT_HEAD_RSP = 3'd2,
    SEND_DATA     = 3'd3,
    WAIT_DATA_RSP = 3'd4,
    DONE          = 3'd5,
    ERROR         = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               stalling;
  logic               progress;
  logic [ERR_W-1:0]   to_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    tick_d       = '0;
    stalling     = 1'b0;
    progress     = 1'b0;
    to_code      = '0;
    tx_req_ready = 1'b0;
    ob_vld       = 1'b0;
    ob_type      = '0;
    sel_head     = 1'b0;
    start_rd     = 1'b0;
    rd_en        = 1'b0;
    ib_rsp_ready = 1'b0;
    done_vld     = 1'b0;
    done_status  = 1'b0;
    done_err     = '0;
    rel_buf      = 1'b0;

    case (state_q)
      IDLE: begin
        tx_req_ready = 1'b1;
        if (tx_req_vld) begin
          len_d = tx_req_len;
          if (tx_req_len == '0) begin
            state_d = ERROR;
            err_d   = E_LEN;
          end else begin
            state_d = SEND_HEAD;
          end
        end
      end
      SEND_HEAD: begin
        ob_vld   = 1'b1;
        ob_type  = HEAD_T;
        sel_head = 1'b1;
        stalling = 1'b1;
        to_code  = E_TO_OBH;
        progress = ob_ready;
        if (ob_ready) state_d = WAIT_HEAD_RSP;
      end
      WAIT_HEAD_RSP: begin
        ib_rsp_ready = 1'b1;
        stalling     = 1'b1;
        to_code      = E_TO_IBH;
        progress     = ib_rsp_vld;
        if (ib_rsp_vld) begin
          if (ib_rsp_status == ST_ERR) begin
            state_d = ERROR;
            err_d   = ib_rsp_err;
          end else if (ib_rsp_type != HEAD_T) begin
            state_d = ERROR;
            err_d   = E_TYPE;
          end else begin
            state_d = SEND_DATA;
            cnt_d   = '0;
          end
        end
      end
      SEND_DATA: begin
        ob_vld   = rd_vld;
        ob_type  = DATA_T;
        rd_en    = rd_vld & ob_ready;
        stalling = 1'b1;
        to_code  = E_TO_OBD;
        progress = rd_vld & ob_ready;
        if (rd_vld & ob_ready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = WAIT_DATA_RSP;
        end
      end
      WAIT_DATA_RSP: begin
        ib_rsp_ready = 1'b1;
        stalling     = 1'b1;
        to_code      = E_TO_IBD;
        progress     = ib_rsp_vld;
        if (ib_rsp_vld) begin
          if (ib_rsp_status == ST_ERR) begin
            state_d = ERROR;
            err_d   = ib_rsp_err;
          end else if (ib_rsp_type != DATA_T) begin
            state_d = ERROR;
            err_d   = E_TYPE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_vld    = 1'b1;
        done_status = ST_OK;
        rel_buf     = done_ready;
        if (done_ready) state_d = IDLE;
      end
      ERROR: begin
        done_vld     = 1'b1;
        done_status  = ST_ERR;
        done_err     = err_q;
        ib_rsp_ready = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Timeout only fires on a stalled cycle, so a transfer in the same cycle wins.
    if (stalling && !progress && (tick_q == TICK_MAX)) begin
      state_d = ERROR;
      err_d   = to_code;
    end

    // Any state change or transfer restarts the stall count; it cannot pass
    // TICK_MAX because reaching it forces a state change.
    if (stalling && !progress && (state_d == state_q)) begin
      tick_d = tick_q + TICK_W'(1);
    end

    start_rd = (state_d == SEND_DATA) && (state_q != SEND_DATA);
  end

endmodule

// File: tb/tb_tpu_ctl.sv
// Testbench for tpu_ctl: a scenario driver issues packets with planned stalls
// and responses, pushing the reference outcome into a queue; a monitor counts
// flits/pulses per packet and compares them on each completion handshake.

`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 2
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef HEAD_FLIT_TYPE
`define HEAD_FLIT_TYPE 2'd1
`endif
`ifndef DATA_FLIT_TYPE
`define DATA_FLIT_TYPE 2'd2
`endif
`ifndef RSP_STATUS_OK
`define RSP_STATUS_OK 1'b0
`endif
`ifndef RSP_STATUS_ERR
`define RSP_STATUS_ERR 1'b1
`endif
`ifndef NO_BUF_AVAILABLE
`define NO_BUF_AVAILABLE 4'd1
`endif
`ifndef BAD_TX_LEN
`define BAD_TX_LEN 4'd8
`endif
`ifndef BAD_RSP_TYPE
`define BAD_RSP_TYPE 4'd9
`endif
`ifndef TIME_OUT_OB_HEAD
`define TIME_OUT_OB_HEAD 4'd10
`endif
`ifndef TIME_OUT_IB_HEAD_RSP
`define TIME_OUT_IB_HEAD_RSP 4'd11
`endif
`ifndef TIME_OUT_OB_DATA
`define TIME_OUT_OB_DATA 4'd12
`endif
`ifndef TIME_OUT_IB_DATA_RSP
`define TIME_OUT_IB_DATA_RSP 4'd13
`endif

module tb_tpu_ctl;
  localparam int unsigned LEN_W = 8;
  localparam int          HOLD  = 16;
  localparam int unsigned TW    = `NOU_TYPE_WIDTH;
  localparam int unsigned EW    = `NOU_ERR_CODE_WIDTH;

  localparam int HEAD_I  = `HEAD_FLIT_TYPE;
  localparam int DATA_I  = `DATA_FLIT_TYPE;
  localparam int OK_I    = `RSP_STATUS_OK;
  localparam int ERR_I   = `RSP_STATUS_ERR;
  localparam int NOBUF_I = `NO_BUF_AVAILABLE;
  localparam int BLEN_I  = `BAD_TX_LEN;
  localparam int BTYP_I  = `BAD_RSP_TYPE;
  localparam int TOBH_I  = `TIME_OUT_OB_HEAD;
  localparam int TIBH_I  = `TIME_OUT_IB_HEAD_RSP;
  localparam int TOBD_I  = `TIME_OUT_OB_DATA;
  localparam int TIBD_I  = `TIME_OUT_IB_DATA_RSP;

  logic clk = 1'b0;
  logic rst;
  logic tx_req_vld, tx_req_ready;
  logic [LEN_W-1:0] tx_req_len;
  logic ob_vld, sel_head, ob_ready, start_rd, rd_vld, rd_en;
  logic [TW-1:0] ob_type, ib_rsp_type;
  logic ib_rsp_vld, ib_rsp_status, ib_rsp_ready;
  logic [EW-1:0] ib_rsp_err, done_err;
  logic done_vld, done_status, done_ready, rel_buf;

  always #5 clk = ~clk;

  tpu_ctl #(.LEN_W(LEN_W), .TICK_HOLD(HOLD), .TICK_W(16)) dut (
    .clk(clk), .rst(rst),
    .tx_req_vld(tx_req_vld), .tx_req_len(tx_req_len), .tx_req_ready(tx_req_ready),
    .ob_vld(ob_vld), .ob_type(ob_type), .sel_head(sel_head), .ob_ready(ob_ready),
    .start_rd(start_rd), .rd_vld(rd_vld), .rd_en(rd_en),
    .ib_rsp_vld(ib_rsp_vld), .ib_rsp_type(ib_rsp_type), .ib_rsp_status(ib_rsp_status),
    .ib_rsp_err(ib_rsp_err), .ib_rsp_ready(ib_rsp_ready),
    .done_vld(done_vld), .done_status(done_status), .done_err(done_err),
    .done_ready(done_ready), .rel_buf(rel_buf)
  );

  // One packet: stall before head accept (h), response delays (-1 = never),
  // response contents, cycles done_ready held low (k), reset after n flits.
  typedef struct {
    int len; int h;
    int hd; int hstat; int htype; int herr;
    int dd; int dstat; int dtype; int derr;
    int k; int rst_after;
  } scn_t;

  typedef struct {
    int st; int err; int nhead; int ndata; int nstart; int nrel; int lat;
  } exp_t;

  int gap [0:255];      // stall cycles before data flit i
  bit gap_rd [0:255];   // stall by rd_vld low (1) or by ob_ready low (0)

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference outcome from the protocol rules: each waiting stage tolerates
  // at most HOLD stalled cycles; HOLD+1 stalled cycles raise that stage's timeout.
  function automatic exp_t model(input scn_t s);
    exp_t e;
    bit   fin;
    e = '{st: ERR_I, err: 0, nhead: 0, ndata: 0, nstart: 0, nrel: 0, lat: 1};
    fin = 1'b0;
    if (s.len == 0) begin
      e.err = BLEN_I; fin = 1'b1;
    end
    if (!fin && s.h > HOLD) begin
      e.err = TOBH_I; e.lat += HOLD + 1; fin = 1'b1;
    end
    if (!fin) begin
      e.lat += s.h + 1; e.nhead = 1;
      if (s.hd < 0 || s.hd > HOLD) begin
        e.err = TIBH_I; e.lat += HOLD + 1; fin = 1'b1;
      end else begin
        e.lat += s.hd + 1;
        if (s.hstat == ERR_I) begin e.err = s.herr; fin = 1'b1; end
        else if (s.htype != HEAD_I) begin e.err = BTYP_I; fin = 1'b1; end
      end
    end
    if (!fin) begin
      e.nstart = 1;
      for (int i = 0; i < s.len && !fin; i++) begin
        if (gap[i] > HOLD) begin
          e.err = TOBD_I; e.lat += HOLD + 1; fin = 1'b1;
        end else begin
          e.lat += gap[i] + 1; e.ndata++;
        end
      end
    end
    if (!fin) begin
      if (s.dd < 0 || s.dd > HOLD) begin
        e.err = TIBD_I; e.lat += HOLD + 1; fin = 1'b1;
      end else begin
        e.lat += s.dd + 1;
        if (s.dstat == ERR_I) begin e.err = s.derr; fin = 1'b1; end
        else if (s.dtype != DATA_I) begin e.err = BTYP_I; fin = 1'b1; end
      end
    end
    if (!fin) begin
      e.st = OK_I; e.err = 0; e.nrel = 1;
    end
    e.lat += 1 + s.k;
    return e;
  endfunction

  task automatic drive_idle();
    tx_req_vld = 1'b0; tx_req_len = '0;
    ob_ready = 1'b0; rd_vld = 1'b0;
    ib_rsp_vld = 1'b0; ib_rsp_type = '0; ib_rsp_status = 1'b0; ib_rsp_err = '0;
    done_ready = 1'b0;
  endtask

  function automatic scn_t base(input int len);
    scn_t s;
    s = '{len: len, h: 0, hd: 0, hstat: OK_I, htype: HEAD_I, herr: 0,
          dd: 0, dstat: OK_I, dtype: DATA_I, derr: 0, k: 0, rst_after: -1};
    for (int i = 0; i < 256; i++) begin gap[i] = 0; gap_rd[i] = 1'b0; end
    return s;
  endfunction

  localparam int P_HEAD = 0, P_HRSP = 1, P_DATA = 2, P_DRSP = 3, P_WAIT = 4, P_DONE = 5;

  task automatic run(input scn_t s);
    int ph, c, i, dcnt;
    bit fin;
    if (s.rst_after < 0) exp_q.push_back(model(s));
    @(negedge clk);
    drive_idle();
    tx_req_vld = 1'b1;
    tx_req_len = LEN_W'(s.len);
    ph = P_HEAD; c = 0; i = 0; dcnt = 0; fin = 1'b0;
    for (int budget = 0; budget < 3000 && !fin; budget++) begin
      @(negedge clk);
      drive_idle();
      #1;
      if (done_vld && ph != P_DONE) ph = P_DONE;
      case (ph)
        P_HEAD: begin
          ob_ready = (c >= s.h);
          #1;
          if (ob_vld && ob_ready && ob_type == TW'(HEAD_I)) begin ph = P_HRSP; c = 0; end
          else c++;
        end
        P_HRSP, P_DRSP: begin
          if (ph == P_HRSP && s.hd >= 0 && c >= s.hd) begin
            ib_rsp_vld = 1'b1; ib_rsp_type = TW'(s.htype);
            ib_rsp_status = s.hstat[0]; ib_rsp_err = EW'(s.herr);
          end
          if (ph == P_DRSP && s.dd >= 0 && c >= s.dd) begin
            ib_rsp_vld = 1'b1; ib_rsp_type = TW'(s.dtype);
            ib_rsp_status = s.dstat[0]; ib_rsp_err = EW'(s.derr);
          end
          #1;
          if (ib_rsp_vld && ib_rsp_ready) begin
            ph = (ph == P_HRSP) ? P_DATA : P_WAIT; c = 0;
          end else c++;
        end
        P_DATA: begin
          if (s.rst_after >= 0 && i == s.rst_after) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            fin = 1'b1;
          end else begin
            if (c < gap[i]) begin
              rd_vld   = gap_rd[i] ? 1'b0 : 1'b1;
              ob_ready = gap_rd[i] ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
              rd_vld = 1'b1; ob_ready = 1'b1;
            end
            #1;
            if (ob_vld && ob_ready && ob_type == TW'(DATA_I)) begin
              i++; c = 0;
              if (i == s.len) ph = P_DRSP;
            end else c++;
          end
        end
        P_DONE: begin
          if (dcnt >= s.k) done_ready = 1'b1;
          #1;
          if (done_vld && done_ready) fin = 1'b1;
          else dcnt++;
        end
        default: ;
      endcase
    end
    if (!fin) begin
      chk("packet_cycle_budget", 0, 1);
      exp_q.delete();
      @(negedge clk); drive_idle(); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
    end
  endtask

  // Monitor
  int  cyc = 0, req_cyc = 0;
  int  n_head, n_data, n_rd, n_start, n_rel;
  bit  post_rst = 1'b0, hold_pend = 1'b0;
  logic hold_st;
  logic [EW-1:0] hold_err;

  always @(negedge clk) begin
    #4;
    if (rst) begin
      post_rst  = 1'b1;
      hold_pend = 1'b0;
    end else begin
      if (post_rst) begin
        chk("rst_tx_req_ready", tx_req_ready, 1);
        chk("rst_other_outputs",
            {ob_vld, ob_type, sel_head, start_rd, rd_en, ib_rsp_ready,
             done_vld, done_status, done_err, rel_buf}, 0);
        post_rst = 1'b0;
      end
      cyc++;
      if (tx_req_vld && tx_req_ready) begin
        req_cyc = cyc;
        n_head = 0; n_data = 0; n_rd = 0; n_start = 0; n_rel = 0;
      end
      if (ob_vld && ob_ready && sel_head && ob_type == TW'(HEAD_I)) n_head++;
      if (ob_vld && ob_ready && !sel_head && ob_type == TW'(DATA_I)) n_data++;
      if (rd_en) n_rd++;
      if (start_rd) n_start++;
      if (rel_buf) n_rel++;
      if (rd_en || (ob_vld && !sel_head)) begin
        chk("rd_en_matches_transfer", rd_en, ob_vld && ob_ready && rd_vld && !sel_head);
      end
      if (hold_pend) begin
        chk("done_vld_held", done_vld, 1);
        chk("done_fields_held", {done_status, done_err}, {hold_st, hold_err});
      end
      hold_pend = done_vld && !done_ready;
      hold_st   = done_status;
      hold_err  = done_err;
      if (done_vld && done_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_status", done_status, e.st);
          chk("done_err", done_err, e.err);
          chk("head_flits", n_head, e.nhead);
          chk("data_flits", n_data, e.ndata);
          chk("rd_en_pulses", n_rd, e.ndata);
          chk("start_rd_pulses", n_start, e.nstart);
          chk("rel_buf_pulses", n_rel, e.nrel);
          chk("latency", cyc - req_cyc + 1, e.lat);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    scn_t s;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    s = base(4); run(s);                                    // nominal, 9 cycles
    s = base(3); s.h = 1;                                   // backpressure
    gap[1] = 5; gap_rd[1] = 1'b1; gap[2] = 1; run(s);
    s = base(4); s.hstat = ERR_I; s.herr = NOBUF_I; run(s); // remote error
    s = base(2); s.dd = -1; run(s);                         // data rsp timeout
    s = base(2); s.dd = HOLD; run(s);                       // rsp on last stall cycle
    s = base(2); s.dd = HOLD + 1; run(s);
    s = base(0); run(s);                                    // bad len
    s = base(3); s.htype = DATA_I; run(s);                  // bad head rsp type
    s = base(2); s.dtype = HEAD_I; run(s);                  // bad data rsp type
    s = base(2); s.dstat = ERR_I; s.derr = 5; s.dtype = HEAD_I; run(s);
    s = base(1); s.k = 10; run(s);                          // done held
    s = base(0); s.k = 10; run(s);
    s = base(1); s.h = HOLD; run(s);
    s = base(1); s.h = HOLD + 1; run(s);                    // head timeout
    s = base(1); s.hd = -1; run(s);                         // head rsp timeout
    s = base(3); gap[1] = HOLD; run(s);
    s = base(3); gap[2] = HOLD + 1; gap_rd[2] = 1'b1; run(s); // data timeout
    s = base(5); s.rst_after = 2; run(s);                   // reset mid-stream
    s = base(1); run(s);
    s = base(255); run(s);                                  // maximum length

    for (int n = 0; n < 40; n++) begin
      s = base(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)));
      s.h     = ($urandom_range(0, 11) == 0) ? HOLD + 1 : int'($urandom_range(0, 3));
      s.hd    = ($urandom_range(0, 11) == 0) ? HOLD + int'($urandom_range(0, 1)) : int'($urandom_range(0, 4));
      s.hstat = ($urandom_range(0, 7) == 0) ? ERR_I : OK_I;
      s.htype = ($urandom_range(0, 7) == 0) ? DATA_I : HEAD_I;
      s.herr  = int'($urandom_range(1, 7));
      s.dd    = ($urandom_range(0, 11) == 0) ? HOLD + int'($urandom_range(0, 1)) : int'($urandom_range(0, 4));
      s.dstat = ($urandom_range(0, 7) == 0) ? ERR_I : OK_I;
      s.dtype = ($urandom_range(0, 7) == 0) ? HEAD_I : DATA_I;
      s.derr  = int'($urandom_range(1, 7));
      s.k     = int'($urandom_range(0, 3));
      for (int i = 0; i < 12; i++) begin
        gap[i]    = ($urandom_range(0, 39) == 0) ? HOLD + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
        gap_rd[i] = 1'($urandom_range(0, 1));
      end
      run(s);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
